// File: rtl/tape_line_buffer.sv
// Two-slot line buffer between the CAS player byte port and the 64-bit image store.
// Demand misses fill the LRU slot; each completed demand access may queue a prefetch of the next line.
module tape_line_buffer #(
  parameter int ADDR_W     = 27,
  parameter int LINE_BYTES = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ram_a,
  input  logic              ram_rd,
  output logic [7:0]        ram_di,
  output logic              buff_mem_ready,
  input  logic [ADDR_W-1:0] cas_size,
  input  logic              image_load,
  input  logic              rewind,
  output logic              cas_end,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ready,
  input  logic [63:0]       mem_dout
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int TAG_W = ADDR_W - OFF_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, DONE, PREFETCH} state_t;

  state_t            state;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] cas_size_q;
  logic [1:0]        slot_valid;
  logic [TAG_W-1:0]  slot_tag  [2];
  logic [63:0]       slot_data [2];
  logic              lru;
  logic              pf_sched;
  logic              pf_slot;
  logic [TAG_W-1:0]  pf_tag;
  logic              req_pending;
  logic              abort_q;

  logic              flush;
  logic              accept;
  logic [ADDR_W-1:0] size_eff;
  logic [TAG_W-1:0]  req_tag;
  logic [TAG_W-1:0]  next_tag;
  logic              next_carry;
  logic              next_in_range;
  logic              next_present;
  logic              hit0, hit1, hit, hit_slot;
  logic              out_of_range;
  logic              kill_end;
  logic [5:0]        bit_off;
  logic [7:0]        hit_byte;
  logic [7:0]        fill_byte;

  always_comb begin
    flush        = image_load | rewind;
    accept       = ram_rd & buff_mem_ready;
    size_eff     = image_load ? cas_size : cas_size_q;
    req_tag      = req_addr[ADDR_W-1:OFF_W];
    bit_off      = {req_addr[OFF_W-1:0], 3'b000};
    {next_carry, next_tag} = {1'b0, req_tag} + {{TAG_W{1'b0}}, 1'b1};
    // A carry out means the line wrapped past the top of the address space.
    next_in_range = !next_carry && ({next_tag, {OFF_W{1'b0}}} < cas_size_q);
    hit0         = slot_valid[0] && (slot_tag[0] == req_tag);
    hit1         = slot_valid[1] && (slot_tag[1] == req_tag);
    hit          = hit0 | hit1;
    hit_slot     = !hit0;
    next_present = (slot_valid[0] && (slot_tag[0] == next_tag)) ||
                   (slot_valid[1] && (slot_tag[1] == next_tag));
    out_of_range = req_addr >= cas_size_q;
    kill_end     = req_addr >= size_eff;
    hit_byte     = slot_data[hit_slot][bit_off +: 8];
    fill_byte    = mem_dout[bit_off +: 8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      req_addr       <= '0;
      cas_size_q     <= '0;
      slot_valid     <= '0;
      slot_tag       <= '{default: '0};
      slot_data      <= '{default: '0};
      lru            <= 1'b0;
      pf_sched       <= 1'b0;
      pf_slot        <= 1'b0;
      pf_tag         <= '0;
      req_pending    <= 1'b0;
      abort_q        <= 1'b0;
      ram_di         <= '0;
      buff_mem_ready <= 1'b1;
      cas_end        <= 1'b0;
      mem_addr       <= '0;
      mem_rd         <= 1'b0;
    end else begin
      if (flush) begin
        slot_valid <= '0;
        pf_sched   <= 1'b0;
      end
      if (image_load) cas_size_q <= cas_size;

      case (state)
        IDLE: begin
          if (accept) begin
            req_addr       <= ram_a;
            buff_mem_ready <= 1'b0;
            state          <= LOOKUP;
          end
        end

        LOOKUP: begin
          state          <= DONE;
          buff_mem_ready <= 1'b1;
          if (flush) begin
            ram_di  <= '0;
            cas_end <= kill_end;
          end else if (out_of_range) begin
            ram_di  <= '0;
            cas_end <= 1'b1;
          end else if (hit) begin
            ram_di  <= hit_byte;
            cas_end <= 1'b0;
            lru     <= !hit_slot;
            if (next_in_range && !next_present) begin
              pf_sched <= 1'b1;
              pf_tag   <= next_tag;
              pf_slot  <= !hit_slot;
            end
          end else begin
            mem_addr       <= {req_tag, {OFF_W{1'b0}}};
            mem_rd         <= 1'b1;
            buff_mem_ready <= 1'b0;
            state          <= FILL;
          end
        end

        FILL: begin
          if (mem_ready) begin
            mem_rd         <= 1'b0;
            abort_q        <= 1'b0;
            buff_mem_ready <= 1'b1;
            state          <= DONE;
            if (flush || abort_q) begin
              ram_di  <= '0;
              cas_end <= kill_end;
            end else begin
              slot_valid[lru] <= 1'b1;
              slot_tag[lru]   <= req_tag;
              slot_data[lru]  <= mem_dout;
              ram_di          <= fill_byte;
              cas_end         <= 1'b0;
              lru             <= !lru;
              if (next_in_range) begin
                pf_sched <= 1'b1;
                pf_tag   <= next_tag;
                pf_slot  <= !lru;
              end
            end
          end else if (flush) begin
            abort_q <= 1'b1;
          end
        end

        DONE: begin
          pf_sched <= 1'b0;
          if (pf_sched && !flush) begin
            mem_addr <= {pf_tag, {OFF_W{1'b0}}};
            mem_rd   <= 1'b1;
            state    <= PREFETCH;
            if (accept) begin
              req_addr       <= ram_a;
              req_pending    <= 1'b1;
              buff_mem_ready <= 1'b0;
            end
          end else if (accept) begin
            req_addr       <= ram_a;
            buff_mem_ready <= 1'b0;
            state          <= LOOKUP;
          end else begin
            state <= IDLE;
          end
        end

        PREFETCH: begin
          if (accept) begin
            req_addr       <= ram_a;
            req_pending    <= 1'b1;
            buff_mem_ready <= 1'b0;
          end
          if (mem_ready) begin
            mem_rd      <= 1'b0;
            abort_q     <= 1'b0;
            req_pending <= 1'b0;
            if (!(flush || abort_q)) begin
              slot_valid[pf_slot] <= 1'b1;
              slot_tag[pf_slot]   <= pf_tag;
              slot_data[pf_slot]  <= mem_dout;
            end
            // A request that waited behind a cancelled prefetch is completed empty.
            if (req_pending || accept) begin
              if (flush || abort_q) begin
                ram_di         <= '0;
                cas_end        <= (accept ? ram_a : req_addr) >= size_eff;
                buff_mem_ready <= 1'b1;
                state          <= DONE;
              end else begin
                state <= LOOKUP;
              end
            end else begin
              state <= IDLE;
            end
          end else if (flush) begin
            abort_q <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
